// File: rtl/alu_seq_muldiv_if.sv
// Handshaked op/result bus for the sequential ALU: operands in, one result out.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Integer ALU with iterative RV32M multiply/divide: 1-cycle logic ops,
// one-bit-per-cycle shift-add multiply and restoring divide.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input logic clk,
  input logic rst,
  alu_seq_muldiv_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
  localparam logic [OPW-1:0] OP_AND   = OPW'(3);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(6);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(7);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(8);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(9);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(10);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(11);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(12);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(13);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(14);
  localparam logic [OPW-1:0] OP_REM   = OPW'(15);
  localparam logic [OPW-1:0] OP_MULH  = OPW'(16);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(17);

  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic           neg;
  } ctl_t;

  state_t           state;
  ctl_t             ctl;
  logic [WIDTH-1:0] acc, lo, opb, res;
  logic [SHW-1:0]   cnt;
  logic             in_ready_q, out_valid_q, busy_q;

  // accept-side decode
  logic [WIDTH-1:0] d1, d2, mag_a, mag_b, quick;
  logic [SHW-1:0]   sh;
  logic             is_mul, is_div, sgn_op, div0, ovf, iter, neg;

  assign d1 = bus.data1;
  assign d2 = bus.data2;
  assign sh = d2[SHW-1:0];

  always_comb begin
    is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULHU) || (bus.op == OP_MULH);
    is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU) ||
             (bus.op == OP_REM) || (bus.op == OP_REMU);
    sgn_op = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    div0   = (d2 == '0);
    ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) && (d1 == MINV) && (d2 == '1);
    iter   = is_mul || (is_div && !div0 && !ovf);
    mag_a  = (sgn_op && d1[WIDTH-1]) ? -d1 : d1;
    mag_b  = (sgn_op && d2[WIDTH-1]) ? -d2 : d2;
    // REM follows the dividend sign; DIV/MULH follow the product of signs
    neg    = (bus.op == OP_REM) ? d1[WIDTH-1] :
             (sgn_op ? (d1[WIDTH-1] ^ d2[WIDTH-1]) : 1'b0);
  end

  always_comb begin
    quick = '0;
    case (bus.op)
      OP_NOP:  quick = d2;
      OP_ADD:  quick = d1 + d2;
      OP_SUB:  quick = d1 - d2;
      OP_AND:  quick = d1 & d2;
      OP_OR:   quick = d1 | d2;
      OP_XOR:  quick = d1 ^ d2;
      OP_SLL:  quick = d1 << sh;
      OP_SRL:  quick = d1 >> sh;
      OP_SRA:  quick = $unsigned($signed(d1) >>> sh);
      OP_SLT:  quick = {{(WIDTH-1){1'b0}}, $signed(d1) < $signed(d2)};
      OP_SLTU: quick = {{(WIDTH-1){1'b0}}, d1 < d2};
      OP_DIV:  quick = div0 ? '1 : MINV;
      OP_DIVU: quick = '1;
      OP_REM:  quick = div0 ? d1 : '0;
      OP_REMU: quick = d1;
      default: quick = '0;
    endcase
  end

  // one iteration step; {acc,lo} is product for mul, {rem,quotient} for div
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ok, ctl_mul;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    ctl_mul = (ctl.op == OP_MUL) || (ctl.op == OP_MULHU) || (ctl.op == OP_MULH);
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    div_sh  = {acc, lo[WIDTH-1]};
    div_ok  = div_sh >= {1'b0, opb};
    div_rem = div_ok ? WIDTH'(div_sh - {1'b0, opb}) : div_sh[WIDTH-1:0];
  end

  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH-1:0]   quo_n, rem_n, fix_res;

  always_comb begin
    prod_n  = ctl.neg ? -{acc, lo} : {acc, lo};
    quo_n   = ctl.neg ? -lo  : lo;
    rem_n   = ctl.neg ? -acc : acc;
    fix_res = '0;
    case (ctl.op)
      OP_MUL:   fix_res = prod_n[WIDTH-1:0];
      OP_MULHU: fix_res = acc;
      OP_MULH:  fix_res = prod_n[2*WIDTH-1:WIDTH];
      OP_DIV:   fix_res = quo_n;
      OP_DIVU:  fix_res = lo;
      OP_REM:   fix_res = rem_n;
      OP_REMU:  fix_res = acc;
      default:  fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ctl         <= '0;
      acc         <= '0;
      lo          <= '0;
      opb         <= '0;
      cnt         <= '0;
      res         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ctl.op     <= bus.op;
          ctl.neg    <= neg;
          cnt        <= '0;
          in_ready_q <= 1'b0;
          if (iter) begin
            state  <= CALC;
            busy_q <= 1'b1;
            acc    <= '0;
            lo     <= mag_a;
            opb    <= mag_b;
          end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res         <= quick;
          end
        end
        CALC: begin
          if (ctl_mul) begin
            {acc, lo} <= {mul_sum, lo[WIDTH-1:1]};
          end else begin
            acc <= div_rem;
            lo  <= {lo[WIDTH-2:0], div_ok};
          end
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          state       <= DONE;
          res         <= fix_res;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          res         <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = res;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed + random checks of alu_seq_muldiv with a result/latency scoreboard.
module tb_alu_seq_muldiv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_muldiv_if #(.WIDTH(32), .OPW(5)) bus ();
  alu_seq_muldiv #(.WIDTH(32), .OPW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [31:0] q_val[$];
  int          q_lat[$];

  localparam logic [31:0] MIN = 32'h8000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned pu;
    longint          ps;
    logic [31:0]     r;
    logic            ov;
    ov = (a == MIN) && (b == 32'hFFFF_FFFF);
    pu = 64'(a) * 64'(b);
    ps = longint'($signed(a)) * longint'($signed(b));
    case (op)
      0:  r = b;
      1:  r = a + b;
      2:  r = a - b;
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = a << b[4:0];
      7:  r = a >> b[4:0];
      8:  r = $unsigned($signed(a) >>> b[4:0]);
      9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10: r = (a < b) ? 32'd1 : 32'd0;
      11: r = pu[31:0];
      12: r = pu[63:32];
      13: r = (b == 0) ? 32'hFFFF_FFFF : ov ? MIN : $unsigned($signed(a) / $signed(b));
      14: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      15: r = (b == 0) ? a : ov ? 32'd0 : $unsigned($signed(a) % $signed(b));
      16: r = ps[63:32];
      17: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 11 || op == 12 || op == 16) return 34;
    if (op == 13 || op == 15) return (b == 0 || (a == MIN && b == 32'hFFFF_FFFF)) ? 1 : 34;
    if (op == 14 || op == 17) return (b == 0) ? 1 : 34;
    return 1;
  endfunction

  // issue one op, then check result, latency, hold under backpressure and release
  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int hold);
    logic [31:0] ev;
    int          el, n;
    logic        b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
    q_val.push_back(exp);
    q_lat.push_back(lat_of(op, a, b));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom); bus.data1 = $urandom; bus.data2 = $urandom;
    n = 1;
    @(negedge clk);
    b1 = bus.busy;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ev = q_val.pop_front();
    el = q_lat.pop_front();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out"}, bus.out, ev);
    chk({tag, "_lat"}, 32'(n), 32'(el));
    chk({tag, "_busy"}, 32'(b1), (el > 1) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_out"}, bus.out, ev);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    // consume while offering a new op: it must not be taken in the same cycle
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 5'd1; bus.data1 = 32'd1; bus.data2 = 32'd1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_rel_out"}, bus.out, 32'd0);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.data1 = '0; bus.data2 = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out", bus.out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("add",   5'd1,  32'd5,          32'd7,          32'd12,          0);
    run("sub",   5'd2,  32'd0,          32'd1,          32'hFFFF_FFFF,   0);
    run("sra",   5'd8,  MIN,            32'h24,         32'hF800_0000,   0);
    run("slt",   5'd9,  32'hFFFF_FFFF,  32'd1,          32'd1,           0);
    run("sltu",  5'd10, 32'hFFFF_FFFF,  32'd1,          32'd0,           0);
    run("nop",   5'd0,  32'd3,          32'h1234_5678,  32'h1234_5678,   0);
    run("undef", 5'd20, 32'd3,          32'd4,          32'd0,           0);
    run("mul",   5'd11, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,   0);
    run("mulhu", 5'd12, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,   0);
    run("mulh",  5'd16, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,   0);
    run("div",   5'd13, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   0);
    run("rem",   5'd15, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   0);
    run("divu",  5'd14, 32'd100,        32'd7,          32'd14,          0);
    run("remu",  5'd17, 32'd100,        32'd7,          32'd2,           5);
    run("div0",  5'd13, 32'd9,          32'd0,          32'hFFFF_FFFF,   0);
    run("rem0",  5'd15, 32'd9,          32'd0,          32'd9,           0);
    run("divov", 5'd13, MIN,            32'hFFFF_FFFF,  MIN,             0);
    run("remov", 5'd15, MIN,            32'hFFFF_FFFF,  32'd0,           0);
    run("addhold", 5'd1, 32'hFFFF_FFFF, 32'd2,          32'd1,           5);

    for (int i = 0; i < 12; i++) begin
      rop = 5'($urandom_range(0, 19));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run("rnd", rop, ra, rb, model(rop, ra, rb), i % 2);
    end

    // reset in the middle of a divide
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 5'd13; bus.data1 = 32'd1000; bus.data2 = 32'd3;
    q_val.push_back(32'd333);
    q_lat.push_back(34);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    q_val.delete();
    q_lat.delete();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out", bus.out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("post_add", 5'd1, 32'd40, 32'd2, 32'd42, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
